req_ack_done_ctrl: RTL and testbench
====================================

REQ_ACK_DONE_CTRL -- requirements
Module: req_ack_done_ctrl

Interface
REQ-001 SHALL have parameter ACK_MAX, default 5: last cycle after req rise in which ack is accepted.
REQ-002 SHALL have parameter DONE_MAX, default 100: last cycle after ack in which done is accepted.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  2  per-requester transaction request, level, held until grant.
REQ-006 SHALL have port grant  output  2  one-hot, one-cycle pulse marking the accepted requester.
REQ-007 SHALL have port req  output  1  request to the shared responder.
REQ-008 SHALL have port ack  input  1  responder acknowledge.
REQ-009 SHALL have port done  input  1  responder completion.
REQ-010 SHALL have port clr_status  input  1  clears status_reg.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port owner  output  1  index of the current or last granted requester.
REQ-013 SHALL have port cmpl  output  2  one-hot, one-cycle completion pulse to the owner.
REQ-014 SHALL have port err_pulse  output  1  one-cycle protocol-failure pulse.
REQ-015 SHALL have port err_code  output  2  01 = ack timeout, 10 = done timeout; holds until the next error or reset.
REQ-016 SHALL have port status_reg  output  1  sticky error flag.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, WAIT_DONE and ERR.
REQ-018 IDLE with any start bit set SHALL move to REQ on the next edge, with grant[winner]=1 and req=1 in the first REQ cycle.
REQ-019 Arbitration SHALL be round-robin, favouring the requester not served last; the pointer toggles after every completion or error, and after reset requester 0 has priority.
REQ-020 A single active start SHALL win regardless of the pointer; owner SHALL update in the grant cycle.
REQ-021 In REQ, counter cnt SHALL be 0 in the first cycle and increment each cycle; req SHALL stay 1 throughout REQ.
REQ-022 ack sampled with cnt in 1..ACK_MAX SHALL move to WAIT_DONE; ack at cnt=0 SHALL be ignored.
REQ-023 cnt==ACK_MAX without ack SHALL move to ERR with err_code=01.
REQ-024 In WAIT_DONE, req SHALL be 0 and cnt SHALL be 1 in the first cycle, i.e. the cycle after ack.
REQ-025 done sampled with cnt in 1..DONE_MAX SHALL move to IDLE, with cmpl[owner]=1 in the first IDLE cycle.
REQ-026 cnt==DONE_MAX without done SHALL move to ERR with err_code=10.
REQ-027 done or ack outside its accepting state SHALL be ignored.
REQ-028 ERR SHALL last exactly one cycle with err_pulse=1, then go to IDLE.
REQ-029 status_reg SHALL be set in the cycle after err_pulse and remain 1 until clr_status.
REQ-030 When clr_status coincides with a set, the set SHALL win.
REQ-031 Deassertion of start after grant SHALL NOT affect the transaction in flight.
REQ-032 The minimum gap between transactions SHALL be one IDLE cycle.
REQ-033 The cnt width SHALL be sized to DONE_MAX, with no wrap before a timeout.

Reset
REQ-034 rst SHALL force IDLE on the next edge, and SHALL take priority over all other inputs, including mid-transaction.
REQ-035 The reset values SHALL be: grant, req, busy, owner, cmpl, err_pulse, err_code, status_reg = 0; cnt = 0; arbitration pointer favouring requester 0.
REQ-036 A reset during WAIT_DONE SHALL produce no cmpl pulse and no err_pulse.

Verification
REQ-037 start=01; ack at cnt=3; done 10 cycles after ack -> grant=01 and req rise together, req high 4 cycles, cmpl=01 one cycle, status_reg=0.
REQ-038 start=10, ack never arrives -> req high 6 cycles (cnt 0..5), then err_pulse=1 and err_code=01, status_reg=1 the following cycle and held.
REQ-039 Done at cnt=100 -> cmpl pulse with no error; done withheld through cnt=100 -> err_code=10, status_reg=1.
REQ-040 start=11 held for 3 transactions -> grants 01, 10, 01, with each grant at least one IDLE cycle apart.
REQ-041 ack only at cnt=0 -> ignored and ack timeout reported; clr_status together with err_pulse's set cycle -> status_reg remains 1.
REQ-042 rst asserted during WAIT_DONE -> all outputs 0 on the next cycle and no cmpl or err_pulse.

Source files
------------

// File: rtl/req_ack_done_ctrl.sv
// Purpose : arbitrate two requesters onto one req/ack/done responder, time out each phase, report errors.
// Latency : grant and req rise one cycle after start is seen in IDLE; cmpl one cycle after done; err_pulse one cycle after timeout.
// Backpr. : requesters hold start (level) until granted; at most one transaction in flight, at least one IDLE cycle between.
//
// Ports
//   clk, rst           : single clock, synchronous active-high reset
//   start[1:0]         : per-requester request level, held until grant
//   grant[1:0]         : one-hot one-cycle pulse in the first REQ cycle
//   req                : request to the shared responder, high for the whole REQ state
//   ack, done          : responder handshake inputs
//   clr_status         : clears the sticky status flag (a simultaneous set wins)
//   busy               : high whenever the controller is not IDLE
//   owner              : index of the current or most recently granted requester
//   cmpl[1:0]          : one-hot one-cycle completion pulse to the owner
//   err_pulse          : one-cycle protocol failure pulse (the ERR state)
//   err_code[1:0]      : 01 ack timeout, 10 done timeout; held until next error or reset
//   status_reg         : sticky error flag
module req_ack_done_ctrl #(
    parameter int ACK_MAX  = 5,
    parameter int DONE_MAX = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] start,
    output logic [1:0] grant,
    output logic       req,
    input  logic       ack,
    input  logic       done,
    input  logic       clr_status,
    output logic       busy,
    output logic       owner,
    output logic [1:0] cmpl,
    output logic       err_pulse,
    output logic [1:0] err_code,
    output logic       status_reg
);

    // The counter must reach the larger of the two limits without wrapping.
    localparam int CNT_MAX = (DONE_MAX > ACK_MAX) ? DONE_MAX : ACK_MAX;
    localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_MAX);
    localparam logic [CNT_W-1:0] DONE_LIM = CNT_W'(DONE_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] ERR_ACK_TO  = 2'b01;
    localparam logic [1:0] ERR_DONE_TO = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REQ       = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_ERR       = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_grant;
    logic [1:0]       w_grant_nxt;
    logic [1:0]       r_cmpl;
    logic [1:0]       w_cmpl_nxt;
    logic             r_owner;
    logic             w_owner_nxt;
    logic             r_prio;       // requester index that wins a tie
    logic             w_prio_nxt;
    logic [1:0]       r_err_code;
    logic [1:0]       w_err_code_nxt;
    logic             r_status;
    logic             w_status_nxt;
    logic             w_win;
    logic             w_req;
    logic             w_busy;
    logic             w_err_pulse;

    // Round-robin pick: a lone requester always wins, a tie goes to r_prio.
    always_comb begin
        w_win = 1'b0;
        if (start == 2'b10) begin
            w_win = 1'b1;
        end else if (start == 2'b11) begin
            w_win = r_prio;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state, datapath next values and state-decoded outputs.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_grant_nxt    = 2'b00;
        w_cmpl_nxt     = 2'b00;
        w_owner_nxt    = r_owner;
        w_prio_nxt     = r_prio;
        w_err_code_nxt = r_err_code;
        w_status_nxt   = r_status;
        w_req          = 1'b0;
        w_busy         = 1'b1;
        w_err_pulse    = 1'b0;

        // Clear first so that a set from ERR below overrides it.
        if (clr_status) begin
            w_status_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                w_busy    = 1'b0;
                w_cnt_nxt = '0;
                if (start != 2'b00) begin
                    w_state_nxt = S_REQ;
                    w_owner_nxt = w_win;
                    w_grant_nxt = w_win ? 2'b10 : 2'b01;
                end
            end

            S_REQ: begin
                w_req = 1'b1;
                // An ack in the very first REQ cycle (cnt 0) is too early and ignored.
                if (ack && (r_cnt != '0)) begin
                    w_state_nxt = S_WAIT_DONE;
                    w_cnt_nxt   = CNT_ONE;
                end else if (r_cnt == ACK_LIM) begin
                    w_state_nxt    = S_ERR;
                    w_cnt_nxt      = '0;
                    w_err_code_nxt = ERR_ACK_TO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_WAIT_DONE: begin
                // cnt starts at 1 here, so done is accepted from the first cycle.
                if (done) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_cmpl_nxt  = r_owner ? 2'b10 : 2'b01;
                    w_prio_nxt  = ~r_owner;
                end else if (r_cnt == DONE_LIM) begin
                    w_state_nxt    = S_ERR;
                    w_cnt_nxt      = '0;
                    w_err_code_nxt = ERR_DONE_TO;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end

            S_ERR: begin
                w_err_pulse  = 1'b1;
                w_state_nxt  = S_IDLE;
                w_cnt_nxt    = '0;
                w_status_nxt = 1'b1;
                // A failed transaction still counts as a turn for its owner.
                w_prio_nxt   = ~r_owner;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_grant    <= 2'b00;
            r_cmpl     <= 2'b00;
            r_owner    <= 1'b0;
            r_prio     <= 1'b0;
            r_err_code <= 2'b00;
            r_status   <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_cmpl     <= w_cmpl_nxt;
            r_owner    <= w_owner_nxt;
            r_prio     <= w_prio_nxt;
            r_err_code <= w_err_code_nxt;
            r_status   <= w_status_nxt;
        end
    end

    assign grant      = r_grant;
    assign req        = w_req;
    assign busy       = w_busy;
    assign owner      = r_owner;
    assign cmpl       = r_cmpl;
    assign err_pulse  = w_err_pulse;
    assign err_code   = r_err_code;
    assign status_reg = r_status;

endmodule

// File: tb/tb_req_ack_done_ctrl.sv
// Purpose : directed test of req_ack_done_ctrl with an event scoreboard.
// Latency : stimulus drives 1 time unit after posedge; monitor samples on negedge.
// Backpr. : none; each expected grant/cmpl/err event is queued before it can appear.
module tb_req_ack_done_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] start;
    logic [1:0] grant;
    logic       req;
    logic       ack;
    logic       done;
    logic       clr_status;
    logic       busy;
    logic       owner;
    logic [1:0] cmpl;
    logic       err_pulse;
    logic [1:0] err_code;
    logic       status_reg;

    logic [10:0] outs;
    assign outs = {grant, req, busy, owner, cmpl, err_pulse, err_code, status_reg};

    req_ack_done_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .grant      (grant),
        .req        (req),
        .ack        (ack),
        .done       (done),
        .clr_status (clr_status),
        .busy       (busy),
        .owner      (owner),
        .cmpl       (cmpl),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .status_reg (status_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] K_GRANT = 2'd0;
    localparam logic [1:0] K_CMPL  = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] grant;
        logic [1:0] cmpl;
        logic [1:0] code;
        logic       owner;
        logic [7:0] req_len;
    } ev_t;

    ev_t exp_q[$];

    int   n_chk;
    int   n_fail;
    logic mon_en;
    int   req_run;
    logic prev_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input logic [1:0] kind, input logic [1:0] g, input logic [1:0] c,
                           input logic [1:0] code, input logic own, input int len);
        ev_t e;
        e.kind    = kind;
        e.grant   = g;
        e.cmpl    = c;
        e.code    = code;
        e.owner   = own;
        e.req_len = 8'(len);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every grant, cmpl or err_pulse must match the next queued expectation.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en && !rst) begin
            if (grant != 2'b00) begin
                req_run = 1;
            end else if (req) begin
                req_run = req_run + 1;
            end
            if ((grant != 2'b00) || (cmpl != 2'b00) || err_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", {grant, cmpl, err_pulse}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    case (e.kind)
                        K_GRANT: begin
                            chk("grant_onehot", {grant, cmpl, err_pulse}, {e.grant, 2'b00, 1'b0});
                            chk("grant_owner", owner, e.owner);
                            chk("grant_with_req", req, 1);
                            chk("idle_gap_before_grant", prev_busy, 0);
                        end
                        K_CMPL: begin
                            chk("cmpl_onehot", {grant, cmpl, err_pulse}, {2'b00, e.cmpl, 1'b0});
                            chk("cmpl_req_len", req_run, e.req_len);
                        end
                        default: begin
                            chk("err_event", {grant, cmpl, err_pulse, err_code}, {2'b00, 2'b00, 1'b1, e.code});
                            chk("err_req_len", req_run, e.req_len);
                        end
                    endcase
                end
            end
            prev_busy = busy;
        end
    end

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        mon_en     = 1'b0;
        req_run    = 0;
        prev_busy  = 1'b0;
        rst        = 1'b1;
        start      = 2'b00;
        ack        = 1'b0;
        done       = 1'b0;
        clr_status = 1'b0;

        step(2);
        chk("reset_outputs", outs, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        step(1);

        // Requester 0, ack at cnt 3, done 10 cycles after ack; start dropped after grant.
        start = 2'b01;
        push_ev(K_GRANT, 2'b01, 2'b00, 2'b00, 1'b0, 0);
        step(1); start = 2'b00;
        step(3); ack = 1'b1;
        step(1); ack = 1'b0;
        chk("busy_in_wait_done", busy, 1);
        chk("req_low_in_wait_done", req, 0);
        step(9); done = 1'b1;
        push_ev(K_CMPL, 2'b00, 2'b01, 2'b00, 1'b0, 4);
        step(1); done = 1'b0;
        chk("status_after_cmpl", status_reg, 0);
        step(2);

        // Requester 1, ack never arrives: req high cnt 0..5 then ack timeout.
        start = 2'b10;
        push_ev(K_GRANT, 2'b10, 2'b00, 2'b00, 1'b1, 0);
        step(1); start = 2'b00;
        push_ev(K_ERR, 2'b00, 2'b00, 2'b01, 1'b1, 6);
        step(6);
        chk("status_not_set_in_err", status_reg, 0);
        step(1);
        chk("status_set_after_err", status_reg, 1);
        chk("err_code_ack_timeout", err_code, 2'b01);
        step(3);
        chk("status_sticky", status_reg, 1);
        chk("err_code_held", err_code, 2'b01);
        clr_status = 1'b1;
        step(1); clr_status = 1'b0;
        chk("status_cleared", status_reg, 0);

        // Ack only at cnt 0 is ignored; clr_status during ERR loses to the set.
        start = 2'b01;
        push_ev(K_GRANT, 2'b01, 2'b00, 2'b00, 1'b0, 0);
        step(1); start = 2'b00; ack = 1'b1;
        step(1); ack = 1'b0;
        push_ev(K_ERR, 2'b00, 2'b00, 2'b01, 1'b0, 6);
        step(5); clr_status = 1'b1;
        step(1); clr_status = 1'b0;
        chk("set_beats_clr", status_reg, 1);
        clr_status = 1'b1;
        step(1); clr_status = 1'b0;
        chk("status_cleared_again", status_reg, 0);

        // Stray ack/done in IDLE start nothing.
        ack = 1'b1; done = 1'b1;
        step(3);
        chk("idle_ignores_ack_done", busy, 0);
        ack = 1'b0; done = 1'b0;
        step(1);

        // Lone requester 0 wins although priority sits with 1; done at cnt = DONE_MAX.
        start = 2'b01;
        push_ev(K_GRANT, 2'b01, 2'b00, 2'b00, 1'b0, 0);
        step(1); start = 2'b00;
        step(1); ack = 1'b1;
        step(1); ack = 1'b0;
        step(99); done = 1'b1;
        push_ev(K_CMPL, 2'b00, 2'b01, 2'b00, 1'b0, 2);
        step(1); done = 1'b0;
        chk("done_at_limit_no_err", status_reg, 0);
        step(1);

        // Done withheld through cnt = DONE_MAX; done in REQ is ignored.
        start = 2'b10;
        push_ev(K_GRANT, 2'b10, 2'b00, 2'b00, 1'b1, 0);
        step(1); start = 2'b00; done = 1'b1;
        step(1); done = 1'b0; ack = 1'b1;
        step(1); ack = 1'b0;
        push_ev(K_ERR, 2'b00, 2'b00, 2'b10, 1'b1, 2);
        step(100);
        step(1);
        chk("status_after_done_timeout", status_reg, 1);
        chk("err_code_done_timeout", err_code, 2'b10);
        clr_status = 1'b1;
        step(1); clr_status = 1'b0;

        // Both requesters held: grants alternate 01, 10, 01 with one IDLE cycle between.
        start = 2'b11;
        for (int i = 0; i < 3; i++) begin
            bit [1:0] g;
            g = (i == 1) ? 2'b10 : 2'b01;
            push_ev(K_GRANT, g, 2'b00, 2'b00, g[1], 0);
            step(1);
            step(1); ack = 1'b1;
            step(1); ack = 1'b0; done = 1'b1;
            push_ev(K_CMPL, 2'b00, g, 2'b00, g[1], 2);
            step(1); done = 1'b0;
        end
        start = 2'b00;
        step(2);

        // Reset in WAIT_DONE: outputs zero next cycle, no cmpl/err, priority back to 0.
        start = 2'b10;
        push_ev(K_GRANT, 2'b10, 2'b00, 2'b00, 1'b1, 0);
        step(1); start = 2'b00;
        step(1); ack = 1'b1;
        step(1); ack = 1'b0;
        step(3); rst = 1'b1; done = 1'b1;
        step(1);
        chk("reset_in_wait_done", outs, 0);
        rst = 1'b0; done = 1'b0;
        step(3);
        start = 2'b11;
        push_ev(K_GRANT, 2'b01, 2'b00, 2'b00, 1'b0, 0);
        step(1); start = 2'b00;
        step(1); ack = 1'b1;
        step(1); ack = 1'b0; done = 1'b1;
        push_ev(K_CMPL, 2'b00, 2'b01, 2'b00, 1'b0, 2);
        step(1); done = 1'b0;
        step(3);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
